dram_to_cram_dma_ctrl: RTL



---
 rtl/dram_to_cram_dma_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dram_to_cram_dma_ctrl.sv
// dram_to_cram_dma_ctrl
// Moves num_words words from DRAM (starting at src_addr) into the
// DRAM-to-CRAM swizzle. Bursts of up to MAX_BURST words are issued one
// at a time. Returned words are forwarded with one cycle of latency.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   start, src_addr, num_words,  command; the other command inputs are
//   cram_addr                    sampled when start is accepted in IDLE
//   busy, done                   transfer status
//   rd_req, rd_addr, rd_len,     burst read request to the memory
//   rd_gnt                       controller
//   rd_data, rd_data_valid       returned read words, in order
//   data_valid, mem_ctrl_data_in,
//   mem_ctrl_data_last           word stream to the swizzle
//   ram_start_addr, dma_mode     CRAM start address and mode for the swizzle
//   swizzle_ready                swizzle is flushed and idle
module dram_to_cram_dma_ctrl #(
  parameter int DWIDTH      = 40,
  parameter int DRAM_AWIDTH = 32,
  parameter int CRAM_AWIDTH = 13,
  parameter int MAX_BURST   = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [DRAM_AWIDTH-1:0] src_addr,
  input  logic [15:0]            num_words,
  input  logic [CRAM_AWIDTH-1:0] cram_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_req,
  output logic [DRAM_AWIDTH-1:0] rd_addr,
  output logic [3:0]             rd_len,
  input  logic                   rd_gnt,
  input  logic [DWIDTH-1:0]      rd_data,
  input  logic                   rd_data_valid,
  output logic                   data_valid,
  output logic [DWIDTH-1:0]      mem_ctrl_data_in,
  output logic                   mem_ctrl_data_last,
  output logic [CRAM_AWIDTH-1:0] ram_start_addr,
  output logic                   dma_mode,
  input  logic                   swizzle_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_ISSUE, S_WAIT_DATA, S_DRAIN, S_DONE
  } state_e;

  localparam logic [15:0] MAX_BURST_W = 16'(MAX_BURST);
  localparam logic [3:0]  MAX_BURST_L = 4'(MAX_BURST);
  localparam logic [1:0]  DRAIN_MIN   = 2'd2;

  state_e                 state_q, state_d;
  logic [DRAM_AWIDTH-1:0] addr_q;    // next burst address
  logic [15:0]            unreq_q;   // words not yet requested
  logic [15:0]            remain_q;  // words not yet returned
  logic [3:0]             burst_q;   // words outstanding in current burst
  logic [1:0]             drain_q;   // cycles spent in DRAIN
  logic                   busy_q;
  logic                   dv_q;
  logic                   last_q;
  logic [DWIDTH-1:0]      data_q;
  logic [CRAM_AWIDTH-1:0] cram_q;

  logic [3:0] len_c;
  logic       accept;
  logic       gnt_acc;
  logic       word_in;

  always_comb begin
    len_c   = (unreq_q >= MAX_BURST_W) ? MAX_BURST_L : unreq_q[3:0];
    accept  = (state_q == S_IDLE) && start;
    gnt_acc = (state_q == S_ISSUE) && rd_gnt;
    // Words arriving in any other state are stale and dropped.
    word_in = (state_q == S_WAIT_DATA) && rd_data_valid;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start) state_d = (num_words == '0) ? S_DONE : S_WAIT_RDY;
      S_WAIT_RDY:  if (swizzle_ready) state_d = S_ISSUE;
      S_ISSUE:     if (rd_gnt) state_d = S_WAIT_DATA;
      S_WAIT_DATA: if (rd_data_valid && burst_q == 4'd1)
                     state_d = (unreq_q != '0) ? S_ISSUE : S_DRAIN;
      // Entering DRAIN coincides with the last word appearing on the
      // output; two further cycles give the swizzle time to see it.
      S_DRAIN:     if (drain_q == DRAIN_MIN && swizzle_ready) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    rd_req             = (state_q == S_ISSUE);
    rd_addr            = addr_q;
    rd_len             = (state_q == S_ISSUE) ? len_c : '0;
    done               = (state_q == S_DONE);
    busy               = busy_q;
    data_valid         = dv_q;
    mem_ctrl_data_in   = data_q;
    mem_ctrl_data_last = last_q;
    ram_start_addr     = cram_q;
    dma_mode           = 1'b1;
  end

  // Datapath and counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q   <= '0;
      unreq_q  <= '0;
      remain_q <= '0;
      burst_q  <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      dv_q     <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      cram_q   <= '0;
    end else begin
      if (accept) begin
        addr_q   <= src_addr;
        unreq_q  <= num_words;
        remain_q <= num_words;
        cram_q   <= cram_addr;
        busy_q   <= 1'b1;
      end
      if (state_q == S_DONE) busy_q <= 1'b0;

      if (gnt_acc) begin
        addr_q  <= addr_q + DRAM_AWIDTH'(len_c);
        unreq_q <= unreq_q - 16'(len_c);
        burst_q <= len_c;
      end else if (word_in) begin
        burst_q <= burst_q - 4'd1;
      end

      if (word_in) begin
        remain_q <= remain_q - 16'd1;
        data_q   <= rd_data;
      end
      dv_q   <= word_in;
      last_q <= word_in && (remain_q == 16'd1);

      if (state_q != S_DRAIN)      drain_q <= '0;
      else if (drain_q != DRAIN_MIN) drain_q <= drain_q + 2'd1;
    end
  end

endmodule
